ftdi_fifo_writer: RTL



---
 rtl/ftdi_fifo_writer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ftdi_fifo_writer.sv
// Byte-pair FIFO draining to the FT232H asynchronous 245-FIFO write port (WR#/TXE#).
// Optional macro FTDI_DROP_COUNT_EN adds the drop_count port and its saturating counter.
module ftdi_fifo_writer #(
   parameter int DEPTH         = 16,
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       en,
   input  logic                       data_valid,
   input  logic [7:0]                 data1_in,
   input  logic [7:0]                 data2_in,
   input  logic                       txe_n,
   output logic                       wr_n,
   output logic [7:0]                 ftdi_data,
   output logic                       data_oe,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       overflow
`ifdef FTDI_DROP_COUNT_EN
   ,
   output logic [15:0]                drop_count
`endif
);

   localparam int AW           = $clog2(DEPTH);
   localparam int GUARD_CYCLES = 3;
   localparam int MAX_A        = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int MAX_B        = (HOLD_CYCLES > GUARD_CYCLES) ? HOLD_CYCLES : GUARD_CYCLES;
   localparam int MAXC         = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW           = $clog2(MAXC) + 1;

   typedef logic [AW:0]   fill_t;
   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] tmr_t;

   localparam fill_t MAX_FILL  = fill_t'(DEPTH - 2);
   localparam tmr_t  SETUP_LD  = tmr_t'(SETUP_CYCLES - 1);
   localparam tmr_t  STROBE_LD = tmr_t'(STROBE_CYCLES - 1);
   localparam tmr_t  HOLD_LD   = tmr_t'(HOLD_CYCLES - 1);
   localparam tmr_t  GUARD_LD  = tmr_t'(GUARD_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GUARD} state_t;

   state_t     state;
   tmr_t       tmr;
   ptr_t       wptr;
   ptr_t       wptr_nxt;
   ptr_t       rptr;
   logic [7:0] mem [DEPTH];
   logic       txe_meta;
   logic       txe_s;
   logic       push;
   logic       drop;
   logic       pop;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         txe_meta <= 1'b1;
         txe_s    <= 1'b1;
      end else begin
         txe_meta <= txe_n;
         txe_s    <= txe_meta;
      end
   end

   // Free-slot check uses the pre-pop count, so a same-cycle pop never enables a push.
   always_comb begin
      push     = data_valid && (fifo_count <= MAX_FILL);
      drop     = data_valid && (fifo_count > MAX_FILL);
      pop      = (state == STROBE) && (tmr == '0);
      wptr_nxt = wptr + ptr_t'(1);
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wptr]     <= data1_in;
         mem[wptr_nxt] <= data2_in;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr       <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + ptr_t'(2);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + fill_t'(2);
            2'b01:   fifo_count <= fifo_count - fill_t'(1);
            2'b11:   fifo_count <= fifo_count + fill_t'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

`ifdef FTDI_DROP_COUNT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         drop_count <= '0;
      end else if (drop && (drop_count != 16'hFFFF)) begin
         drop_count <= drop_count + 16'd1;
      end
   end
`endif

   // en and txe_s are only consulted in IDLE, so a started byte always runs to the end of GUARD.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         tmr       <= '0;
         rptr      <= '0;
         wr_n      <= 1'b1;
         data_oe   <= 1'b0;
         ftdi_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en && (fifo_count != '0) && !txe_s) begin
                  state     <= SETUP;
                  tmr       <= SETUP_LD;
                  ftdi_data <= mem[rptr];
                  data_oe   <= 1'b1;
               end
            end
            SETUP: begin
               if (tmr == '0) begin
                  state <= STROBE;
                  tmr   <= STROBE_LD;
                  wr_n  <= 1'b0;
               end else begin
                  tmr <= tmr - tmr_t'(1);
               end
            end
            STROBE: begin
               if (tmr == '0) begin
                  state <= HOLD;
                  tmr   <= HOLD_LD;
                  wr_n  <= 1'b1;
                  rptr  <= rptr + ptr_t'(1);
               end else begin
                  tmr <= tmr - tmr_t'(1);
               end
            end
            HOLD: begin
               if (tmr == '0) begin
                  state     <= GUARD;
                  tmr       <= GUARD_LD;
                  data_oe   <= 1'b0;
                  ftdi_data <= '0;
               end else begin
                  tmr <= tmr - tmr_t'(1);
               end
            end
            GUARD: begin
               if (tmr == '0) begin
                  state <= IDLE;
               end else begin
                  tmr <= tmr - tmr_t'(1);
               end
            end
            default: begin
               state   <= IDLE;
               wr_n    <= 1'b1;
               data_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule
